// File: rtl/my_br_pkg.sv
// my_br_pkg
//   Shared definitions for the parametrised register bank (my_br_param):
//   default geometry, the clear/run state encoding and a helper that
//   locates port i inside a packed multi-port bus.
package my_br_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } br_state_e;

  // LSB position of port idx in a bus packing ports of width w side by side.
  function automatic int unsigned port_lsb(input int unsigned idx,
                                           input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/my_br_rd_port.sv
// my_br_rd_port
//   One combinational read port of the register bank.
//   Ports:
//     run_i      - bank is in RUN; reads are forced to zero otherwise
//     rd_addr_i  - read address
//     mem_i      - full array contents
//     wr_en_i / wr_addr_i / wr_data_i - write port, used only for forwarding
//     rd_data_o  - read data
//   Macro MY_BR_BYPASS_EN: when defined, a write in progress to the same
//   address is forwarded to rd_data_o in the same cycle.
module my_br_rd_port
  import my_br_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              run_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] mem_i [2**ADDR_W],
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic is_zero;
  assign is_zero = (ZERO_REG != 0) && (rd_addr_i == '0);

`ifdef MY_BR_BYPASS_EN
  logic fwd;
  assign fwd = run_i && wr_en_i && (wr_addr_i == rd_addr_i) && !is_zero;
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  always_comb begin
    rd_data_o = '0;
    if (run_i && !is_zero) begin
      rd_data_o = mem_i[rd_addr_i];
`ifdef MY_BR_BYPASS_EN
      if (fwd) begin
        rd_data_o = wr_data_i;
      end
`endif
    end
  end

endmodule

// File: rtl/my_br_param.sv
// my_br_param
//   Parametrised register bank: NUM_RD combinational read ports, one
//   synchronous write port, a sequenced clear after every reset, an
//   optional hardwired-zero entry 0 and a dropped-write flag.
//   Ports:
//     clk      - rising-edge clock
//     rst_n    - synchronous active-low reset
//     rd_addr  - packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rd_data  - packed read data, port i at [i*DATA_W +: DATA_W]
//     wr_en / wr_addr / wr_data - write port
//     ready    - array cleared, writes accepted
//     wr_drop  - one-cycle pulse after a write discarded during clear
//   Macro MY_BR_BYPASS_EN: same-cycle write-to-read forwarding.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_CLEAR | zeroing one entry per cycle; writes dropped, reads 0
//   ST_RUN   | normal operation; writes accepted
module my_br_param
  import my_br_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_RD   = 2,   // 1..4
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     ready,
  output logic                     wr_drop
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  br_state_e         state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic              ready_q;
  logic              wr_drop_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic run;
  logic wr_ok;
  assign run   = (state_q == ST_RUN);
  assign wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          wr_drop_q <= wr_en;
          clr_idx_q <= clr_idx_q + ADDR_W'(1);
          // Leave on the last index so the counter never wraps.
          if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          wr_drop_q <= 1'b0;
        end
      endcase
    end
  end

  // Array is left untouched on the reset edge; the clear sequence owns it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == ST_CLEAR) begin
        mem_q[clr_idx_q] <= '0;
      end else if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    my_br_rd_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd_port (
      .run_i     (run),
      .rd_addr_i (rd_addr[port_lsb(i, ADDR_W) +: ADDR_W]),
      .mem_i     (mem_q),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_data_o (rd_data[port_lsb(i, DATA_W) +: DATA_W])
    );
  end

  assign ready   = ready_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_my_br_param.sv
// Directed bench for my_br_param: one instance with the hardwired zero
// entry and one without, both driven by the same stimulus.
module tb_my_br_param;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] rd_data_nz;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        ready;
  logic        ready_nz;
  logic        wr_drop;
  logic        wr_drop_nz;

  int total = 0;
  int bad   = 0;

  my_br_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready), .wr_drop(wr_drop)
  );

  my_br_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ready(ready_nz), .wr_drop(wr_drop_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef MY_BR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = {5'd31, 5'd3};
    step();
    step();
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_wr_drop", {31'b0, wr_drop}, 32'd0);
    check("rst_rd0", rd_data[31:0], 32'd0);

    // Clear sequence: ready after exactly 32 edges; write at cycle 5 dropped.
    rst_n = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      step();
      check($sformatf("clr_ready_c%0d", c), {31'b0, ready}, (c == 32) ? 32'd1 : 32'd0);
      check($sformatf("clr_drop_c%0d", c), {31'b0, wr_drop}, (c == 6) ? 32'd1 : 32'd0);
      if (c < 32) begin
        check($sformatf("clr_rd0_c%0d", c), rd_data[31:0], 32'd0);
        check($sformatf("clr_rd1_c%0d", c), rd_data[63:32], 32'd0);
      end
      if (c == 5) begin
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 32'hDEAD_BEEF;
      end else begin
        wr_en = 1'b0;
      end
    end
    check("nz_ready", {31'b0, ready_nz}, 32'd1);
    rd_addr = {5'd31, 5'd31};
    #1;
    check("dropped_addr31", rd_data[63:32], 32'd0);

    // Write 3, read on both ports.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0015;
    rd_addr = {5'd3, 5'd3};
    #1;
    check("w3_same_cycle", rd_data[31:0], BYP ? 32'h15 : 32'h0);
    step();
    wr_en = 1'b0;
    #1;
    check("w3_port0", rd_data[31:0], 32'h15);
    check("w3_port1", rd_data[63:32], 32'h15);
    check("run_wr_drop", {31'b0, wr_drop}, 32'd0);

    // Write to entry 0.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    step();
    wr_en = 1'b0;
    rd_addr = {5'd3, 5'd0};
    #1;
    check("zero_reg_rd", rd_data[31:0], 32'd0);
    check("zero_reg_drop", {31'b0, wr_drop}, 32'd0);
    check("nz_reg0_rd", rd_data_nz[31:0], 32'hFFFF_FFFF);
    check("indep_port1", rd_data[63:32], 32'h15);

    // Write 7 and read it in the same cycle.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h64;
    rd_addr = {5'd3, 5'd7};
    #1;
    check("w7_same_cycle", rd_data[31:0], BYP ? 32'h64 : 32'h0);
    check("w7_other_port", rd_data[63:32], 32'h15);
    step();
    wr_en = 1'b0;
    #1;
    check("w7_next_cycle", rd_data[31:0], 32'h64);

    // Write 1, then reset in RUN: clear reruns and wipes it.
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h78;
    step();
    wr_en = 1'b0;
    rd_addr = {5'd7, 5'd1};
    #1;
    check("w1_rd", rd_data[31:0], 32'h78);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("rerst_ready", {31'b0, ready}, 32'd0);
    check("rerst_rd", rd_data[31:0], 32'd0);
    for (int c = 1; c <= 32; c++) begin
      step();
      if (c == 31) check("rerst_ready_c31", {31'b0, ready}, 32'd0);
    end
    check("rerst_ready_c32", {31'b0, ready}, 32'd1);
    check("rerst_w1_cleared", rd_data[31:0], 32'd0);
    check("rerst_w7_cleared", rd_data[63:32], 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
